dds_frame_parser: RTL and testbench

- Upstream of the DDS control unit. Consumes bytes from the UART receiver and assembles 9-byte parameter frames.
- Validates sync, shape code and XOR checksum, then publishes var_1..var_4 with a stretched data_ready flag.
- The stretched flag lets the 1 MHz control unit sample it reliably.
- Runs entirely in the 100 MHz domain.

---
 rtl/dds_frame_parser_pkg.sv | 21 ++
 rtl/dds_frame_parser_if.sv | 23 ++
 rtl/dds_pulse_stretch.sv | 28 ++
 rtl/dds_frame_parser.sv | 135 +++++++++++++
 tb/tb_dds_frame_parser.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_frame_parser_pkg.sv
// Shared frame constants, reset defaults and parser state encoding.
// Kept in one package so the control unit and the parser agree on reset values.
package dds_frame_parser_pkg;

  localparam logic [7:0]  SYNC_BYTE  = 8'hAA;
  localparam int          FRAME_LEN  = 9;
  localparam logic [7:0]  MAX_SHAPE  = 8'd2;

  localparam logic [7:0]  DEF_SHAPE  = 8'd0;
  localparam logic [15:0] DEF_M      = 16'd10;
  localparam logic [15:0] DEF_A      = 16'd1000;
  localparam logic [15:0] DEF_OFFSET = 16'd1000;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_CHECK   = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

endpackage

// File: rtl/dds_frame_parser_if.sv
// Byte stream in from the UART receiver, parameter set and status out.
// rx_valid is a one-cycle strobe qualifying rx_data; there is no ready/backpressure,
// the consumer must accept every strobed byte in the cycle it is presented.
interface dds_frame_parser_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        data_ready;
  logic [7:0]  var_1;
  logic [15:0] var_2;
  logic [15:0] var_3;
  logic [15:0] var_4;
  logic        frame_err;

  modport master (
    output rx_data, rx_valid,
    input  data_ready, var_1, var_2, var_3, var_4, frame_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output data_ready, var_1, var_2, var_3, var_4, frame_err
  );
endinterface

// File: rtl/dds_pulse_stretch.sv
// Load/countdown stretcher: flag stays high for HOLD cycles after the last load,
// long enough for a slower clock domain to sample it.
module dds_pulse_stretch #(
  parameter int HOLD = 200
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic load,
  output logic flag
);

  localparam int CNT_W = $clog2(HOLD + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(HOLD);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign flag = (cnt != '0);

endmodule

// File: rtl/dds_frame_parser.sv
// Assembles 9-byte parameter frames, validates sync/shape/XOR checksum and
// publishes var_1..var_4 with a stretched data_ready flag.
module dds_frame_parser
  import dds_frame_parser_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int READY_HOLD     = 200
) (
  input  logic                clk_100MHz,
  input  logic                rst_n,
  dds_frame_parser_if.slave   bus,
  output state_t              state_dbg
);

  localparam int                IDLE_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST    = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]        LAST_PAYLOAD = 3'(FRAME_LEN - 2);

  state_t            state;
  logic [2:0]        byte_cnt;
  logic [7:0]        chk;
  logic [IDLE_W-1:0] idle_cnt;

  logic [7:0]        sh_shape;
  logic [15:0]       sh_m;
  logic [15:0]       sh_off;
  logic [15:0]       sh_amp;

  logic [7:0]        var_1_q;
  logic [15:0]       var_2_q;
  logic [15:0]       var_3_q;
  logic [15:0]       var_4_q;
  logic              frame_err_q;
  logic              ready_flag;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      chk         <= '0;
      idle_cnt    <= '0;
      sh_shape    <= '0;
      sh_m        <= '0;
      sh_off      <= '0;
      sh_amp      <= '0;
      var_1_q     <= DEF_SHAPE;
      var_2_q     <= DEF_M;
      var_3_q     <= DEF_OFFSET;
      var_4_q     <= DEF_A;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
            state    <= S_PAYLOAD;
            byte_cnt <= 3'd1;
            chk      <= '0;
            idle_cnt <= '0;
          end
        end

        S_PAYLOAD: begin
          if (bus.rx_valid) begin
            case (byte_cnt)
              3'd1:    sh_shape     <= bus.rx_data;
              3'd2:    sh_m[15:8]   <= bus.rx_data;
              3'd3:    sh_m[7:0]    <= bus.rx_data;
              3'd4:    sh_off[15:8] <= bus.rx_data;
              3'd5:    sh_off[7:0]  <= bus.rx_data;
              3'd6:    sh_amp[15:8] <= bus.rx_data;
              3'd7:    sh_amp[7:0]  <= bus.rx_data;
              default: ;
            endcase
            chk      <= chk ^ bus.rx_data;
            byte_cnt <= byte_cnt + 3'd1;
            idle_cnt <= '0;
            if (byte_cnt == LAST_PAYLOAD) state <= S_CHECK;
          end else if (idle_cnt == IDLE_LAST) begin
            frame_err_q <= 1'b1;
            state       <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        S_CHECK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == chk && sh_shape <= MAX_SHAPE) begin
              state <= S_COMMIT;
            end else begin
              frame_err_q <= 1'b1;
              state       <= S_IDLE;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            frame_err_q <= 1'b1;
            state       <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        // A byte strobed during this single cycle is dropped; the UART byte
        // rate keeps that from happening in practice.
        S_COMMIT: begin
          var_1_q <= sh_shape;
          var_2_q <= sh_m;
          var_3_q <= sh_off;
          var_4_q <= sh_amp;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  dds_pulse_stretch #(
    .HOLD (READY_HOLD)
  ) u_ready_stretch (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .load       (state == S_COMMIT),
    .flag       (ready_flag)
  );

  assign bus.var_1      = var_1_q;
  assign bus.var_2      = var_2_q;
  assign bus.var_3      = var_3_q;
  assign bus.var_4      = var_4_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.data_ready = ready_flag;
  assign state_dbg      = state;

endmodule

// File: tb/tb_dds_frame_parser.sv
// Directed bench for dds_frame_parser: reset, rejects, timeout, back-to-back
// commits, garbage before sync and reset in the middle of a frame.
module tb_dds_frame_parser;
  import dds_frame_parser_pkg::*;

  localparam int T_OUT = 1000;
  localparam int HOLD  = 200;

  // bytes 1..7 XOR: 59 / F5 / 5B / 27
  localparam logic [71:0] FRAME_M100   = 72'hAA_01_0064_03E8_07D0_59;
  localparam logic [71:0] FRAME_BADCHK = 72'hAA_01_0064_03E8_07D0_5A;
  localparam logic [71:0] FRAME_SHAPE3 = 72'hAA_03_0064_03E8_07D0_5B;
  localparam logic [71:0] FRAME_M200   = 72'hAA_01_00C8_03E8_07D0_F5;
  localparam logic [71:0] FRAME_MISC   = 72'hAA_02_1234_0100_0200_27;

  logic   clk_100MHz;
  logic   rst_n;
  state_t state_dbg;
  int     checks;
  int     errors;
  int     err_pulses;

  dds_frame_parser_if bus ();

  dds_frame_parser #(
    .TIMEOUT_CYCLES (T_OUT),
    .READY_HOLD     (HOLD)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .bus        (bus),
    .state_dbg  (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  always @(negedge clk_100MHz) if (bus.frame_err === 1'b1) err_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 2000000", $time);
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_100MHz);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk_100MHz);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [71:0] f);
    for (int i = 8; i >= 0; i--) send_byte(f[i*8 +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  task automatic measure_hold(output int n);
    n = 0;
    while (bus.data_ready === 1'b1 && n < 4 * HOLD) begin
      n++;
      @(posedge clk_100MHz);
      #1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    idle(3);
    checks++;
    if (bus.var_1 !== 8'd0 || bus.var_2 !== 16'd10 || bus.var_3 !== 16'd1000 || bus.var_4 !== 16'd1000) begin
      errors++;
      $display("FAIL reset_vars: got %0d %0d %0d %0d required 0 10 1000 1000",
               bus.var_1, bus.var_2, bus.var_3, bus.var_4);
    end
    checks++;
    if (bus.data_ready !== 1'b0 || bus.frame_err !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL reset_flags: ready %b err %b state %0d required 0 0 0",
               bus.data_ready, bus.frame_err, state_dbg);
    end
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_bad_checksum;
    int e0;
    e0 = err_pulses;
    send_frame(FRAME_BADCHK);
    checks++;
    if (bus.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL badchk_err: frame_err %b required 1", bus.frame_err);
    end
    idle(1);
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL badchk_pulse_width: frame_err %b required 0", bus.frame_err);
    end
    idle(5);
    checks++;
    if (bus.data_ready !== 1'b0 || bus.var_1 !== 8'd0 || bus.var_2 !== 16'd10 ||
        bus.var_3 !== 16'd1000 || bus.var_4 !== 16'd1000) begin
      errors++;
      $display("FAIL badchk_outputs: ready %b vars %0d %0d %0d %0d required 0 / 0 10 1000 1000",
               bus.data_ready, bus.var_1, bus.var_2, bus.var_3, bus.var_4);
    end
    checks++;
    if (err_pulses - e0 !== 1) begin
      errors++;
      $display("FAIL badchk_pulse_count: %0d pulses required 1", err_pulses - e0);
    end
  endtask

  task automatic test_bad_shape;
    int e0;
    e0 = err_pulses;
    send_frame(FRAME_SHAPE3);
    idle(5);
    checks++;
    if (err_pulses - e0 !== 1) begin
      errors++;
      $display("FAIL shape3_err: %0d pulses required 1", err_pulses - e0);
    end
    checks++;
    if (bus.data_ready !== 1'b0 || bus.var_1 !== 8'd0 || bus.var_2 !== 16'd10) begin
      errors++;
      $display("FAIL shape3_outputs: ready %b var_1 %0d var_2 %0d required 0 0 10",
               bus.data_ready, bus.var_1, bus.var_2);
    end
  endtask

  task automatic test_timeout_then_good;
    int n;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    n = 0;
    while (bus.frame_err !== 1'b1 && n < T_OUT + 50) begin
      @(posedge clk_100MHz);
      #1;
      n++;
    end
    checks++;
    if (n !== T_OUT) begin
      errors++;
      $display("FAIL timeout_cycles: frame_err after %0d cycles required %0d", n, T_OUT);
    end
    checks++;
    if (state_dbg !== S_IDLE || bus.var_2 !== 16'd10 || bus.data_ready !== 1'b0) begin
      errors++;
      $display("FAIL timeout_state: state %0d var_2 %0d ready %b required 0 10 0",
               state_dbg, bus.var_2, bus.data_ready);
    end
    idle(3);
    send_frame(FRAME_M100);
    checks++;
    if (bus.data_ready !== 1'b0 || bus.var_2 !== 16'd10) begin
      errors++;
      $display("FAIL good_latency_early: ready %b var_2 %0d one cycle after CHK required 0 10",
               bus.data_ready, bus.var_2);
    end
    idle(1);
    checks++;
    if (bus.var_1 !== 8'd1 || bus.var_2 !== 16'd100 || bus.var_3 !== 16'd1000 || bus.var_4 !== 16'd2000) begin
      errors++;
      $display("FAIL good_vars: got %0d %0d %0d %0d required 1 100 1000 2000",
               bus.var_1, bus.var_2, bus.var_3, bus.var_4);
    end
    measure_hold(n);
    checks++;
    if (n !== HOLD) begin
      errors++;
      $display("FAIL good_hold: data_ready high %0d cycles required %0d", n, HOLD);
    end
  endtask

  task automatic test_back_to_back;
    int lows;
    int n;
    idle(5);
    send_frame(FRAME_M100);
    idle(1);
    lows = 0;
    for (int i = 0; i < 90; i++) begin
      idle(1);
      if (bus.data_ready !== 1'b1) lows++;
    end
    for (int i = 8; i >= 0; i--) begin
      send_byte(FRAME_M200[i*8 +: 8]);
      if (bus.data_ready !== 1'b1) lows++;
    end
    idle(1);
    if (bus.data_ready !== 1'b1) lows++;
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL b2b_continuous: data_ready low %0d cycles during first hold required 0", lows);
    end
    checks++;
    if (bus.var_2 !== 16'd200) begin
      errors++;
      $display("FAIL b2b_var2: got %0d required 200", bus.var_2);
    end
    measure_hold(n);
    checks++;
    if (n !== HOLD) begin
      errors++;
      $display("FAIL b2b_hold: data_ready high %0d cycles after second commit required %0d", n, HOLD);
    end
  endtask

  task automatic test_garbage_then_good;
    int e0;
    e0 = err_pulses;
    send_byte(8'h55);
    send_byte(8'h12);
    send_frame(FRAME_MISC);
    idle(1);
    checks++;
    if (bus.var_1 !== 8'd2 || bus.var_2 !== 16'h1234 || bus.var_3 !== 16'h0100 || bus.var_4 !== 16'h0200) begin
      errors++;
      $display("FAIL garbage_vars: got %h %h %h %h required 02 1234 0100 0200",
               bus.var_1, bus.var_2, bus.var_3, bus.var_4);
    end
    checks++;
    if (bus.data_ready !== 1'b1 || err_pulses !== e0) begin
      errors++;
      $display("FAIL garbage_flags: ready %b err pulses %0d required 1 0",
               bus.data_ready, err_pulses - e0);
    end
  endtask

  task automatic test_reset_mid_frame;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h64);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.var_1 !== 8'd0 || bus.var_2 !== 16'd10 || bus.var_3 !== 16'd1000 || bus.var_4 !== 16'd1000) begin
      errors++;
      $display("FAIL midreset_vars: got %0d %0d %0d %0d required 0 10 1000 1000",
               bus.var_1, bus.var_2, bus.var_3, bus.var_4);
    end
    checks++;
    if (bus.data_ready !== 1'b0 || state_dbg !== S_IDLE) begin
      errors++;
      $display("FAIL midreset_state: ready %b state %0d required 0 0", bus.data_ready, state_dbg);
    end
    @(negedge clk_100MHz);
    rst_n = 1'b1;
    idle(2);
    send_frame(FRAME_M200);
    idle(1);
    checks++;
    if (bus.var_2 !== 16'd200 || bus.data_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_recover: var_2 %0d ready %b required 200 1", bus.var_2, bus.data_ready);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks     = 0;
    errors     = 0;
    err_pulses = 0;
    test_reset();
    test_bad_checksum();
    test_bad_shape();
    test_timeout_then_good();
    test_back_to_back();
    test_garbage_then_good();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
